// File: rtl/beacon_burst_gen.sv
// -----------------------------------------------------------------------------
// beacon_burst_gen
//   Sampled beacon envelope generator. It emits bursts of ON_SAMPLES samples at
//   AMPLITUDE, each followed by OFF_SAMPLES samples at FLOOR. One sample is
//   emitted every CLK_DIV clocks. It runs either for a fixed number of bursts
//   (BURSTS != 0) or until stopped (BURSTS == 0). The output can key a
//   transmitter or act as a loopback stimulus for the receiver detection chain.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   start_i        start a sequence (only honoured in IDLE)
//   stop_i         abort a sequence (any state, highest priority)
//   signal_o       current sample value, updated together with valid_o
//   valid_o        one-cycle sample strobe
//   burst_active_o high while the FSM is in ON
//   burst_count_o  completed bursts since the last start, saturating
//   done_o         one-cycle pulse when BURSTS bursts have completed
// -----------------------------------------------------------------------------
module beacon_burst_gen #(
    parameter int              DW          = 16,
    parameter int              COUNT_BITS  = 16,
    parameter int              CLK_DIV     = 4,
    parameter int              ON_SAMPLES  = 70,
    parameter int              OFF_SAMPLES = 930,
    parameter int              BURSTS      = 0,
    parameter logic [DW-1:0]   AMPLITUDE   = 'h4000,
    parameter logic [DW-1:0]   FLOOR       = 'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic [DW-1:0]         signal_o,
    output logic                  valid_o,
    output logic                  burst_active_o,
    output logic [COUNT_BITS-1:0] burst_count_o,
    output logic                  done_o
);

    localparam int DIV_BITS = $clog2(CLK_DIV);

    localparam logic [DIV_BITS-1:0]   DIV_LAST    = DIV_BITS'(CLK_DIV - 1);
    localparam logic [COUNT_BITS-1:0] ON_LAST     = COUNT_BITS'(ON_SAMPLES - 1);
    localparam logic [COUNT_BITS-1:0] OFF_LAST    = COUNT_BITS'(OFF_SAMPLES - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX   = '1;
    localparam logic [32:0]           BURST_LIMIT = {1'b0, 32'(BURSTS)};
    localparam bit                    FIXED_COUNT = (BURSTS != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t                  state_reg,  state_next;
    logic [DIV_BITS-1:0]     div_reg,    div_next;
    logic [COUNT_BITS-1:0]   phase_reg,  phase_next;
    logic [COUNT_BITS-1:0]   count_reg,  count_next;
    logic [DW-1:0]           signal_reg, signal_next;
    logic                    valid_reg,  valid_next;
    logic                    done_reg,   done_next;

    logic                    sample_edge;
    logic                    limit_reached;

    assign sample_edge   = (div_reg == DIV_LAST);
    // count >= BURSTS, written as count+1 > BURSTS so the expression never
    // degenerates into a constant comparison when BURSTS is zero.
    assign limit_reached = FIXED_COUNT &&
                           (({1'b0, 32'(count_reg)} + 33'd1) > BURST_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            div_reg    <= '0;
            phase_reg  <= '0;
            count_reg  <= '0;
            signal_reg <= FLOOR;
            valid_reg  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            phase_reg  <= phase_next;
            count_reg  <= count_next;
            signal_reg <= signal_next;
            valid_reg  <= valid_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        phase_next  = phase_reg;
        count_next  = count_reg;
        signal_next = signal_reg;
        valid_next  = 1'b0;
        done_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_next = ST_ON;
                    div_next   = '0;
                    phase_next = '0;
                    count_next = '0;
                end
            end

            ST_ON, ST_OFF: begin
                if (stop_i) begin
                    // Abort drops any sample that would have landed on this
                    // edge; the burst count is kept for inspection.
                    state_next = ST_IDLE;
                    div_next   = '0;
                    phase_next = '0;
                end else begin
                    div_next = sample_edge ? '0 : div_reg + 1'b1;
                    if (sample_edge) begin
                        valid_next  = 1'b1;
                        signal_next = (state_reg == ST_ON) ? AMPLITUDE : FLOOR;
                        phase_next  = phase_reg + 1'b1;
                        if (state_reg == ST_ON && phase_reg == ON_LAST) begin
                            state_next = ST_OFF;
                            phase_next = '0;
                            if (count_reg != COUNT_MAX) begin
                                count_next = count_reg + 1'b1;
                            end
                        end else if (state_reg == ST_OFF && phase_reg == OFF_LAST) begin
                            phase_next = '0;
                            if (limit_reached) begin
                                state_next = ST_IDLE;
                                done_next  = 1'b1;
                            end else begin
                                state_next = ST_ON;
                            end
                        end
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                div_next   = '0;
                phase_next = '0;
            end
        endcase
    end

    assign signal_o       = signal_reg;
    assign valid_o        = valid_reg;
    assign burst_active_o = (state_reg == ST_ON);
    assign burst_count_o  = count_reg;
    assign done_o         = done_reg;

endmodule

// File: tb/tb_beacon_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_beacon_burst_gen
//   Three generators share one stimulus stream:
//     0: CLK_DIV=4, ON=3, OFF=5, BURSTS=2, AMP=0x1000, FLOOR=0x0010
//     1: same timing, continuous (BURSTS=0)
//     2: CLK_DIV=3, ON=2, OFF=3, continuous, COUNT_BITS=2 (saturating count)
//   The reference works from elapsed time since start: samples emitted so far
//   is t/CLK_DIV, the position inside a burst period decides ON/OFF and level,
//   and completed bursts follow from the sample count.
// -----------------------------------------------------------------------------
module tb_beacon_burst_gen;

    typedef struct packed {
        int          div;
        int          on;
        int          off;
        int          bursts;
        int          cb;
        logic [15:0] amp;
        logic [15:0] flr;
    } cfg_t;

    function automatic cfg_t cfg(input int i);
        cfg_t c;
        case (i)
            0:       c = '{div: 4, on: 3, off: 5, bursts: 2, cb: 16, amp: 16'h1000, flr: 16'h0010};
            1:       c = '{div: 4, on: 3, off: 5, bursts: 0, cb: 16, amp: 16'h1000, flr: 16'h0010};
            default: c = '{div: 3, on: 2, off: 3, bursts: 0, cb: 2,  amp: 16'h1234, flr: 16'h0001};
        endcase
        return c;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;

    logic [15:0] sig_w [3];
    logic        valid_w [3];
    logic        active_w [3];
    logic        done_w [3];
    logic [15:0] cnt_w [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    beacon_burst_gen #(.DW(16), .COUNT_BITS(16), .CLK_DIV(4), .ON_SAMPLES(3), .OFF_SAMPLES(5),
                       .BURSTS(2), .AMPLITUDE(16'h1000), .FLOOR(16'h0010)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
        .signal_o(sig_w[0]), .valid_o(valid_w[0]), .burst_active_o(active_w[0]),
        .burst_count_o(cnt0), .done_o(done_w[0]));

    beacon_burst_gen #(.DW(16), .COUNT_BITS(16), .CLK_DIV(4), .ON_SAMPLES(3), .OFF_SAMPLES(5),
                       .BURSTS(0), .AMPLITUDE(16'h1000), .FLOOR(16'h0010)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
        .signal_o(sig_w[1]), .valid_o(valid_w[1]), .burst_active_o(active_w[1]),
        .burst_count_o(cnt1), .done_o(done_w[1]));

    beacon_burst_gen #(.DW(16), .COUNT_BITS(2), .CLK_DIV(3), .ON_SAMPLES(2), .OFF_SAMPLES(3),
                       .BURSTS(0), .AMPLITUDE(16'h1234), .FLOOR(16'h0001)) u_dut2 (
        .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
        .signal_o(sig_w[2]), .valid_o(valid_w[2]), .burst_active_o(active_w[2]),
        .burst_count_o(cnt2), .done_o(done_w[2]));

    assign cnt_w[0] = cnt0;
    assign cnt_w[1] = cnt1;
    assign cnt_w[2] = {14'd0, cnt2};

    // Reference state
    bit          run [3];
    int          t [3];
    logic [15:0] exp_sig [3];
    logic [15:0] exp_cnt [3];
    logic        exp_valid [3];
    logic        exp_done [3];
    logic        exp_active [3];

    int vectors = 0;
    int miscompares = 0;
    int done_seen = 0;

    function automatic int completed_bursts(input cfg_t c, input int k);
        int n;
        int cap;
        n   = (k >= c.on) ? ((k - c.on) / (c.on + c.off) + 1) : 0;
        cap = (1 << c.cb) - 1;
        return (n > cap) ? cap : n;
    endfunction

    task automatic model_edge(input logic s, input logic p, input logic r);
        cfg_t c;
        int   k;
        int   per;
        for (int i = 0; i < 3; i++) begin
            c   = cfg(i);
            per = c.on + c.off;
            exp_valid[i] = 1'b0;
            exp_done[i]  = 1'b0;
            if (r) begin
                run[i]     = 1'b0;
                exp_sig[i] = c.flr;
                exp_cnt[i] = 16'd0;
            end else if (run[i]) begin
                if (p) begin
                    run[i] = 1'b0;
                end else begin
                    t[i]++;
                    if (t[i] % c.div == 0) begin
                        k            = t[i] / c.div;
                        exp_valid[i] = 1'b1;
                        exp_sig[i]   = (((k - 1) % per) < c.on) ? c.amp : c.flr;
                        exp_cnt[i]   = 16'(completed_bursts(c, k));
                        if (c.bursts != 0 && k == c.bursts * per) begin
                            exp_done[i] = 1'b1;
                            run[i]      = 1'b0;
                        end
                    end
                end
            end else if (s && !p) begin
                run[i]     = 1'b1;
                t[i]       = 0;
                exp_cnt[i] = 16'd0;
            end
            exp_active[i] = run[i] && (((t[i] / c.div) % per) < c.on);
        end
    endtask

    task automatic chk(input string tag, input int inst, input logic [15:0] obs,
                       input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, expv);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic r);
        @(negedge clk);
        start = s;
        stop  = p;
        rst   = r;
        @(posedge clk);
        model_edge(s, p, r);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("valid",  i, 16'(valid_w[i]),  16'(exp_valid[i]));
            chk("signal", i, sig_w[i],         exp_sig[i]);
            chk("active", i, 16'(active_w[i]), 16'(exp_active[i]));
            chk("count",  i, cnt_w[i],         exp_cnt[i]);
            chk("done",   i, 16'(done_w[i]),   16'(exp_done[i]));
        end
        if (done_w[0] === 1'b1) done_seen++;
    endtask

    initial begin
        bit found;

        // Reset state
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // start and stop together in IDLE: nothing happens
        step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Fixed-count run on instance 0 (16 samples, done on the last one);
        // extra start pulses land while every generator is busy.
        step(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 60; n++) step(($urandom_range(7) == 0), 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        vectors++;
        assert (done_seen == 1) else begin
            miscompares++;
            $error("FAIL done_pulses observed=%0d expected=1", done_seen);
        end

        // Continuous runs keep going past 10 bursts on instance 1, then
        // stop lands inside an ON phase.
        repeat (260) step(1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            if (exp_active[1] && (t[1] % 4) == 2 && (t[1] / 4) % 8 == 1) found = 1'b1;
            else step(1'b0, 1'b0, 1'b0);
        end
        vectors++;
        assert (found) else begin
            miscompares++;
            $error("FAIL stop_window observed=0 expected=1");
        end
        step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // Reset right after the second ON sample, then restart
        step(1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // Randomised mix of start / stop / reset
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(19) == 0), ($urandom_range(149) == 0),
                 ($urandom_range(499) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
